spi_slave_core: RTL

SPI mode-0 responder (CPOL=0, CPHA=0) that sits at the far end of the link driven by our SPI master core. It presents a 32-bit word interface to the local Avalon-side logic. Each 32-bit word crosses the link as 4 byte frames. Every byte frame is a separate ss_n-low window carrying 8 bits LSB-first; bytes go in lane order [7:0], [15:8], [23:16], [31:24]. sclk, ss_n and mosi are asynchronous to clk and are oversampled.

---
 rtl/spi_slave_core.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/spi_slave_core.sv
// spi_slave_core
//   SPI mode-0 (CPOL=0, CPHA=0) responder with a 32-bit word interface.
//   A word crosses the link as four byte frames, each its own ss_n-low
//   window, LSB-first, lanes in order [7:0], [15:8], [23:16], [31:24].
//   sclk, ss_n and mosi are asynchronous and oversampled on clk.
//
// Ports
//   clk, reset_n        system clock, asynchronous active-low reset
//   sclk, ss_n, mosi    SPI pins from the master (asynchronous)
//   miso, miso_oe       SPI data out and its output enable
//   tx_data, tx_load    next word to send; load strobe (taken when tx_ready)
//   tx_ready            tx holding register empty
//   rx_data, rx_valid   last complete received word; one-cycle update pulse
//   frame_err           pulse: ss_n rose with 1..7 bits shifted
//   underrun            pulse: word start with no tx word loaded
//   timeout_err         pulse: partial word dropped after IDLE_TIMEOUT idle clks
//
// Handshake: tx_load is a single-cycle strobe accepted only when tx_ready=1
// (or on the cycle a word start empties the holding register); rx_valid is a
// single-cycle pulse with no backpressure, rx_data holds until the next pulse.
module spi_slave_core #(
  parameter int          SYNC_STAGES  = 2,
  parameter logic [31:0] TX_DEFAULT   = 32'h0000_0000,
  parameter int          IDLE_TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        sclk,
  input  logic        ss_n,
  input  logic        mosi,
  output logic        miso,
  output logic        miso_oe,
  input  logic [31:0] tx_data,
  input  logic        tx_load,
  output logic        tx_ready,
  output logic [31:0] rx_data,
  output logic        rx_valid,
  output logic        frame_err,
  output logic        underrun,
  output logic        timeout_err
);

  localparam int             TO_W   = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(IDLE_TIMEOUT);

  typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

  // Synchronizers plus one extra flop per line for edge detection.
  logic [SYNC_STAGES-1:0] r_sclk_sync, r_ss_sync, r_mosi_sync;
  logic                   r_sclk_d, r_ss_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sclk_sync <= '0;
      r_ss_sync   <= '1;
      r_mosi_sync <= '0;
      r_sclk_d    <= 1'b0;
      r_ss_d      <= 1'b1;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
      r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], ss_n};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
      r_sclk_d    <= r_sclk_sync[SYNC_STAGES-1];
      r_ss_d      <= r_ss_sync[SYNC_STAGES-1];
    end
  end

  logic w_sclk_s, w_ss_s, w_mosi_s;
  logic w_sclk_rise, w_sclk_fall, w_ss_fall, w_ss_rise;

  assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
  assign w_ss_s      = r_ss_sync[SYNC_STAGES-1];
  assign w_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
  assign w_sclk_rise =  w_sclk_s & ~r_sclk_d;
  assign w_sclk_fall = ~w_sclk_s &  r_sclk_d;
  assign w_ss_fall   = ~w_ss_s   &  r_ss_d;
  assign w_ss_rise   =  w_ss_s   & ~r_ss_d;

  state_t          r_state;
  logic [3:0]      r_bit_cnt;
  logic [1:0]      r_byte_idx;
  logic [TO_W-1:0] r_to_cnt;
  logic [31:0]     r_tx_shift, r_tx_hold, r_rx_word, r_rx_data;
  logic [7:0]      r_rx_byte;
  logic            r_tx_ready, r_miso, r_miso_oe;
  logic            r_rx_valid, r_frame_err, r_underrun, r_timeout_err;

  logic        w_word_start, w_consume, w_load_acc;
  logic [31:0] w_next_tx;
  logic [4:0]  w_tx_idx;

  assign w_word_start = (r_state == ST_IDLE) & w_ss_fall & (r_byte_idx == 2'd0);
  // A full holding register is emptied by a word start; a load arriving on
  // that same cycle refills it, so the word in flight keeps the old content.
  assign w_consume    = w_word_start & ~r_tx_ready;
  assign w_load_acc   = tx_load & (r_tx_ready | w_consume);
  assign w_next_tx    = w_word_start ? (r_tx_ready ? TX_DEFAULT : r_tx_hold) : r_tx_shift;
  assign w_tx_idx     = {r_byte_idx, r_bit_cnt[2:0]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_bit_cnt     <= '0;
      r_byte_idx    <= '0;
      r_to_cnt      <= '0;
      r_tx_shift    <= TX_DEFAULT;
      r_tx_hold     <= '0;
      r_tx_ready    <= 1'b1;
      r_rx_byte     <= '0;
      r_rx_word     <= '0;
      r_rx_data     <= '0;
      r_miso        <= 1'b0;
      r_miso_oe     <= 1'b0;
      r_rx_valid    <= 1'b0;
      r_frame_err   <= 1'b0;
      r_underrun    <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_rx_valid    <= 1'b0;
      r_frame_err   <= 1'b0;
      r_underrun    <= 1'b0;
      r_timeout_err <= 1'b0;

      if (w_load_acc) begin
        r_tx_hold  <= tx_data;
        r_tx_ready <= 1'b0;
      end else if (w_consume) begin
        r_tx_ready <= 1'b1;
      end

      case (r_state)
        ST_IDLE: begin
          r_miso    <= 1'b0;
          r_miso_oe <= 1'b0;
          r_bit_cnt <= '0;
          if (w_ss_fall) begin
            r_state    <= ST_SHIFT;
            r_miso_oe  <= 1'b1;
            r_to_cnt   <= '0;
            r_tx_shift <= w_next_tx;
            // First bit of this byte goes out immediately; the master
            // samples it on its first sclk rise.
            r_miso     <= w_next_tx[{r_byte_idx, 3'b000}];
            if (w_word_start && r_tx_ready) r_underrun <= 1'b1;
          end else if (r_byte_idx != 2'd0) begin
            if (r_to_cnt == TO_MAX) begin
              r_byte_idx    <= '0;
              r_to_cnt      <= '0;
              r_timeout_err <= 1'b1;
            end else begin
              r_to_cnt <= r_to_cnt + 1'b1;
            end
          end
        end

        ST_SHIFT: begin
          if (w_ss_rise) begin
            r_state   <= ST_IDLE;
            r_miso    <= 1'b0;
            r_miso_oe <= 1'b0;
            r_bit_cnt <= '0;
            if (r_bit_cnt == 4'd8) begin
              r_rx_word[{r_byte_idx, 3'b000} +: 8] <= r_rx_byte;
              if (r_byte_idx == 2'd3) begin
                r_rx_data  <= {r_rx_byte, r_rx_word[23:0]};
                r_rx_valid <= 1'b1;
                r_byte_idx <= '0;
              end else begin
                r_byte_idx <= r_byte_idx + 1'b1;
              end
            end else if (r_bit_cnt != 4'd0) begin
              r_frame_err <= 1'b1;
            end
          end else if (r_bit_cnt != 4'd8) begin
            if (w_sclk_rise) begin
              r_rx_byte[r_bit_cnt[2:0]] <= w_mosi_s;
              r_bit_cnt                 <= r_bit_cnt + 1'b1;
            end else if (w_sclk_fall) begin
              r_miso <= r_tx_shift[w_tx_idx];
            end
          end else begin
            // Byte complete: extra sclk edges are ignored, line parked low.
            r_miso <= 1'b0;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign miso        = r_miso;
  assign miso_oe     = r_miso_oe;
  assign tx_ready    = r_tx_ready;
  assign rx_data     = r_rx_data;
  assign rx_valid    = r_rx_valid;
  assign frame_err   = r_frame_err;
  assign underrun    = r_underrun;
  assign timeout_err = r_timeout_err;

endmodule
